// File: rtl/risc5_irq_timer_if.sv
// ---------------------------------------------------------------------------
// risc5_irq_timer_if
//   RISC5 I/O-port bus bundle between the CPU (master) and a memory-mapped
//   peripheral (slave) occupying a 16-byte window.
//
//   io_en  master->slave  upper address decoded to the peripheral's window
//   adr    master->slave  adr[3:2] register select, adr[1:0] byte lane
//   rd     master->slave  read strobe, one cycle per load
//   wr     master->slave  write strobe, one cycle per store
//   ben    master->slave  1 = byte access
//   din    master->slave  store data, byte already replicated into its lane
//   dout   slave->master  combinational read data
// ---------------------------------------------------------------------------
interface risc5_irq_timer_if;
  logic        io_en;
  logic [3:0]  adr;
  logic        rd;
  logic        wr;
  logic        ben;
  logic [31:0] din;
  logic [31:0] dout;

  modport master (
    output io_en, adr, rd, wr, ben, din,
    input  dout
  );

  modport slave (
    input  io_en, adr, rd, wr, ben, din,
    output dout
  );
endinterface

// File: rtl/risc5_irq_timer.sv
// ---------------------------------------------------------------------------
// risc5_irq_timer
//   Memory-mapped tick timer on the RISC5 I/O port. A prescaler divides clk
//   by TICK_DIV to produce a one-cycle tick; each tick advances TIME. When the
//   incremented TIME equals CMP the pending flag PND is set and, in periodic
//   mode, CMP advances by PERIOD. irq is the registered AND of IE and PND.
//
//   Register map (adr[3:2]):
//     0 TIME    R/W  tick count, wraps
//     1 CMP     R/W  compare value
//     2 CTRL    R/W  bit0 IE, bit1 PND (write 1 clears), bit2 PER
//     3 PERIOD  R/W  reload increment for periodic mode
//
//   Ports:
//     clk   system clock, all state on rising edge
//     rst   asynchronous, active-low reset
//     bus   RISC5 I/O bus, slave side (io_en/adr/rd/wr/ben/din -> dout)
//     irq   interrupt request to CPU, registered
// ---------------------------------------------------------------------------
module risc5_irq_timer #(
  parameter int unsigned TICK_DIV = 40000
) (
  input  logic                     clk,
  input  logic                     rst,
  risc5_irq_timer_if.slave         bus,
  output logic                     irq
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    REG_TIME   = 2'd0,
    REG_CMP    = 2'd1,
    REG_CTRL   = 2'd2,
    REG_PERIOD = 2'd3
  } reg_sel_e;

  logic [PW-1:0] presc_q;
  logic [31:0]   time_q;
  logic [31:0]   cmp_q;
  logic [31:0]   period_q;
  logic          ie_q;
  logic          pnd_q;
  logic          per_q;

  reg_sel_e      sel;
  logic [1:0]    lane;
  logic          wr_en;
  logic          rd_en;
  logic          time_wr;
  logic          cmp_wr;
  logic          ctrl_wr;
  logic          period_wr;
  logic          tick;
  logic [31:0]   time_inc;
  logic          match;

  // Word writes replace all bits; byte writes touch only the addressed lane.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] old_val,
    input logic [31:0] data,
    input logic        byte_en,
    input logic [1:0]  ln
  );
    logic [31:0] r;
    r = old_val;
    if (!byte_en) begin
      r = data;
    end else begin
      r[{ln, 3'b000} +: 8] = data[{ln, 3'b000} +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  always_comb begin
    sel       = reg_sel_e'(bus.adr[3:2]);
    lane      = bus.adr[1:0];
    wr_en     = bus.io_en & bus.wr;
    rd_en     = bus.io_en & bus.rd;
    time_wr   = wr_en & (sel == REG_TIME);
    cmp_wr    = wr_en & (sel == REG_CMP);
    period_wr = wr_en & (sel == REG_PERIOD);
    // CTRL fields all live in byte 0, so byte stores to other lanes are ignored.
    ctrl_wr   = wr_en & (sel == REG_CTRL) & (~bus.ben | (lane == 2'd0));
  end

  // ---------------------------------------------------------------------------
  // Tick generation and compare
  // ---------------------------------------------------------------------------
  always_comb begin
    tick     = (presc_q == PRESC_MAX);
    time_inc = time_q + 32'd1;
    // Compare uses the pre-write TIME so a colliding TIME store cannot mask a match.
    match    = tick & (time_inc == cmp_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (time_wr || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // A TIME store overrides the tick increment in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_q <= '0;
    end else if (time_wr) begin
      time_q <= merge_lane(time_q, bus.din, bus.ben, lane);
    end else if (tick) begin
      time_q <= time_inc;
    end
  end

  // A CMP store overrides the periodic reload in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_q <= '0;
    end else if (cmp_wr) begin
      cmp_q <= merge_lane(cmp_q, bus.din, bus.ben, lane);
    end else if (match && per_q) begin
      cmp_q <= cmp_q + period_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period_q <= '0;
    end else if (period_wr) begin
      period_q <= merge_lane(period_q, bus.din, bus.ben, lane);
    end
  end

  // ---------------------------------------------------------------------------
  // Control, pending flag and interrupt
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie_q  <= 1'b0;
      per_q <= 1'b0;
    end else if (ctrl_wr) begin
      ie_q  <= bus.din[0];
      per_q <= bus.din[2];
    end
  end

  // Set has priority over a software clear arriving in the match cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pnd_q <= 1'b0;
    end else if (match) begin
      pnd_q <= 1'b1;
    end else if (ctrl_wr && bus.din[1]) begin
      pnd_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= ie_q & pnd_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux; byte loads get the full word and the CPU picks the lane
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.dout = '0;
    if (rd_en) begin
      unique case (sel)
        REG_TIME:   bus.dout = time_q;
        REG_CMP:    bus.dout = cmp_q;
        REG_CTRL:   bus.dout = {29'd0, per_q, pnd_q, ie_q};
        REG_PERIOD: bus.dout = period_q;
        default:    bus.dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_risc5_irq_timer.sv
// ---------------------------------------------------------------------------
// tb_risc5_irq_timer
//   Directed bench for risc5_irq_timer with TICK_DIV=4. Inputs change on the
//   falling edge; outputs are sampled in the low phase of the clock.
// ---------------------------------------------------------------------------
module tb_risc5_irq_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic irq;

  risc5_irq_timer_if bus();

  risc5_irq_timer #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives a store at the current falling edge; it lands on the next rising edge.
  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic b);
    bus.io_en = 1'b1;
    bus.wr    = 1'b1;
    bus.adr   = a;
    bus.din   = d;
    bus.ben   = b;
    @(negedge clk);
    bus.io_en = 1'b0;
    bus.wr    = 1'b0;
    bus.ben   = 1'b0;
  endtask

  // Combinational read inside the low phase; consumes no clock edge.
  task automatic check_rd(input string tag, input logic [3:0] a, input logic b,
                          input logic [31:0] exp);
    logic [31:0] d;
    bus.io_en = 1'b1;
    bus.rd    = 1'b1;
    bus.adr   = a;
    bus.ben   = b;
    #1 d = bus.dout;
    #1;
    bus.rd    = 1'b0;
    bus.io_en = 1'b0;
    bus.ben   = 1'b0;
    check(tag, d, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] per_exp [3];
    int          hi;
    per_exp = '{32'd2, 32'd7, 32'd12};

    bus.io_en = 1'b0;
    bus.adr   = '0;
    bus.rd    = 1'b0;
    bus.wr    = 1'b0;
    bus.ben   = 1'b0;
    bus.din   = '0;

    // Reset state
    step(3);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b1;
    check_rd("rst_time",   4'h0, 1'b0, 32'd0);
    check_rd("rst_cmp",    4'h4, 1'b0, 32'd0);
    check_rd("rst_ctrl",   4'h8, 1'b0, 32'd0);
    check_rd("rst_period", 4'hC, 1'b0, 32'd0);

    // dout is zero unless io_en & rd
    bus.io_en = 1'b1; bus.adr = 4'h0;
    #1 check("dout_no_rd", bus.dout, 32'd0);
    bus.io_en = 1'b0; bus.rd = 1'b1;
    #1 check("dout_no_io_en", bus.dout, 32'd0);
    bus.rd = 1'b0;

    // Free run: 40 edges after release -> 10 ticks
    step(40);
    check_rd("free_time", 4'h0, 1'b0, 32'd10);

    // Store with io_en=0 is ignored
    bus.io_en = 1'b0; bus.wr = 1'b1; bus.adr = 4'hC; bus.din = 32'hDEAD_BEEF;
    step(1);
    bus.wr = 1'b0;
    check_rd("no_io_en_wr", 4'hC, 1'b0, 32'd0);

    // One-shot: TIME=0 lands on E0, TIME=3 on E12
    bus_wr(4'h4, 32'd3, 1'b0);
    bus_wr(4'h8, 32'd1, 1'b0);
    bus_wr(4'h0, 32'd0, 1'b0);
    step(11);
    check_rd("os_ctrl_pre", 4'h8, 1'b0, 32'd1);
    step(1);
    check_rd("os_ctrl_pnd", 4'h8, 1'b0, 32'd3);
    check_rd("os_time", 4'h0, 1'b0, 32'd3);
    check("os_irq_lag", {31'd0, irq}, 32'd0);
    step(1);
    check("os_irq", {31'd0, irq}, 32'd1);
    bus_wr(4'h8, 32'd3, 1'b0);
    step(1);
    check("os_irq_clr", {31'd0, irq}, 32'd0);
    hi = 0;
    for (int i = 0; i < 24; i++) begin
      step(1);
      if (irq === 1'b1) hi++;
    end
    check("os_quiet", 32'(hi), 32'd0);
    check_rd("os_ctrl_quiet", 4'h8, 1'b0, 32'd1);

    // Periodic: matches at TIME 2, 7, 12
    bus_wr(4'h4, 32'd2, 1'b0);
    bus_wr(4'hC, 32'd5, 1'b0);
    bus_wr(4'h8, 32'd5, 1'b0);
    bus_wr(4'h0, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 100 && irq !== 1'b1; t++) step(1);
      check($sformatf("per_irq%0d", k), {31'd0, irq}, 32'd1);
      check_rd($sformatf("per_time%0d", k), 4'h0, 1'b0, per_exp[k]);
      bus_wr(4'h8, 32'd7, 1'b0);
      for (int t = 0; t < 10 && irq !== 1'b0; t++) step(1);
      check($sformatf("per_clr%0d", k), {31'd0, irq}, 32'd0);
    end
    check_rd("per_cmp", 4'h4, 1'b0, 32'd17);

    // Byte lanes
    bus_wr(4'h8, 32'd2, 1'b0);
    bus_wr(4'h4, 32'h1122_3344, 1'b0);
    bus_wr(4'h6, 32'hAAAA_AAAA, 1'b1);
    check_rd("byte_cmp", 4'h7, 1'b1, 32'h11AA_3344);
    bus_wr(4'h9, 32'h0505_0505, 1'b1);
    check_rd("byte_ctrl_lane1", 4'h8, 1'b0, 32'd0);
    bus_wr(4'hC, 32'h7F7F_7F7F, 1'b1);
    check_rd("byte_period", 4'hC, 1'b0, 32'h0000_007F);

    // Collision: PND clear in the match cycle (E12)
    bus_wr(4'h4, 32'd3, 1'b0);
    bus_wr(4'h0, 32'd0, 1'b0);
    step(11);
    bus_wr(4'h8, 32'd2, 1'b0);
    check_rd("col_pnd", 4'h8, 1'b0, 32'd2);

    // Collision: TIME write on the tick edge E16
    step(3);
    bus_wr(4'h0, 32'd100, 1'b0);
    check_rd("col_time", 4'h0, 1'b0, 32'd100);
    step(3);
    check_rd("col_time_hold", 4'h0, 1'b0, 32'd100);
    step(1);
    check_rd("col_time_inc", 4'h0, 1'b0, 32'd101);

    // TIME write mid-period restarts the prescaler
    step(1);
    bus_wr(4'h0, 32'd200, 1'b0);
    step(3);
    check_rd("presc_clr_hold", 4'h0, 1'b0, 32'd200);
    step(1);
    check_rd("presc_clr_inc", 4'h0, 1'b0, 32'd201);

    // Wrap to zero matches CMP=0
    bus_wr(4'h8, 32'd3, 1'b0);
    bus_wr(4'h4, 32'd0, 1'b0);
    bus_wr(4'h0, 32'hFFFF_FFFF, 1'b0);
    step(3);
    check_rd("wrap_pre", 4'h0, 1'b0, 32'hFFFF_FFFF);
    step(1);
    check_rd("wrap_time", 4'h0, 1'b0, 32'd0);
    check_rd("wrap_ctrl", 4'h8, 1'b0, 32'd3);
    step(1);
    check("wrap_irq", {31'd0, irq}, 32'd1);

    // Asynchronous reset while irq is high, inside the low phase
    #1 rst = 1'b0;
    #1 check("async_irq", {31'd0, irq}, 32'd0);
    check_rd("async_time",   4'h0, 1'b0, 32'd0);
    check_rd("async_cmp",    4'h4, 1'b0, 32'd0);
    check_rd("async_ctrl",   4'h8, 1'b0, 32'd0);
    check_rd("async_period", 4'hC, 1'b0, 32'd0);
    step(1);
    rst = 1'b1;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
